pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline hazard/flush controller for the NSTAGE-stage in-order core; successor to the fixed 5-bit hold scheme.
//  Sits beside the pipeline registers: detects load-use hazards, absorbs multi-cycle EX holds, sequences branch-redirect flushes.
//  Emits per-register stall/flush vectors, a PC redirect and a sticky hold watchdog flag.
// PARAMETERS
//  NSTAGE     5   pipeline registers incl. PC; bit0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb (NSTAGE>=4)
//  XLEN       32  address width
//  FLUSH_CYC  1   extra cycles if_id is flushed after a redirect (sync ROM latency), 0..7
//  HOLD_MAX   64  EX hold cycles before hold_timeout_o sets
//  CNT_W      16  perf counter width (PIPE_CTRL_PERF_EN only)
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous reset, active-high
//  id_rs1_read_i    in   1       ID reads rs1
//  id_rs1_addr_i    in   5       ID rs1 index
//  id_rs2_read_i    in   1       ID reads rs2
//  id_rs2_addr_i    in   5       ID rs2 index
//  ex_load_i        in   1       instruction in EX is a load
//  ex_rd_addr_i     in   5       EX destination index
//  ex_hold_i        in   1       EX multi-cycle unit busy
//  redirect_i       in   1       EX resolved mispredict/jump
//  redirect_addr_i  in   XLEN    target address
//  stall_o          out  NSTAGE  hold register k
//  flush_o          out  NSTAGE  load bubble into register k
//  pc_redirect_o    out  1       PC loads pc_redirect_addr_o
//  pc_redirect_addr_o out XLEN   redirect target
//  hold_timeout_o   out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, counters 0; reset mid-flush/hold aborts immediately.
//  EXI = NSTAGE-3 (id_ex index). Decisions combinational from inputs+state; state/counters registered.
//  Priority: redirect > ex_hold > load-use; lower-priority request ignored that cycle.
//  Redirect (cycle T): pc_redirect_o=1, addr=redirect_addr_i, flush_o[EXI:1]=1, stall_o=0.
//    If FLUSH_CYC>0 -> FLUSH, fcnt=FLUSH_CYC; each FLUSH cycle flush_o[1]=1, fcnt--, exit to RUN at fcnt==1.
//    Redirect during FLUSH: re-applies T actions, reloads fcnt.
//  EX hold: stall_o[EXI:0]=1, flush_o[EXI+1]=1 (bubble to ex_mem); state HOLD, hcnt++ saturating.
//    hcnt==HOLD_MAX -> hold_timeout_o=1 until rst. ex_hold_i low -> RUN, hcnt=0, no stall that cycle.
//    ex_hold_i in FLUSH: hold actions apply; fcnt frozen; remaining flush after hold drops.
//  Load-use: ex_load_i & ex_rd_addr_i!=0 & ((rs1_read & rs1==rd)|(rs2_read & rs2==rd))
//    -> stall_o[EXI-1:0]=1, flush_o[EXI]=1, exactly one cycle; x0 never hazards.
//  stall_o and flush_o never both set on the same bit; bits above EXI+1 always 0.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: extra outputs stall_cnt_o, flush_cnt_o [CNT_W-1:0]; +1 per cycle any stall_o / per redirect; saturate at all-ones; cleared by rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  defines.v: state encodings RUN/HOLD/FLUSH, stage index constants, PIPE_CTRL_PERF_EN default off.
//  Sub-module pipe_ctrl_hazard: combinational load-use comparator (ID sources vs EX rd).
// TESTING
//  ex_load_i=1, rd=5, rs1_read=1, rs1=5 -> 1 cycle stall_o=00011, flush_o=00100; rd=0 -> no stall.
//  redirect_i pulse, addr=0x0000_0100, FLUSH_CYC=1 -> T: pc_redirect_o=1, flush_o=00110; T+1: flush_o=00010; T+2: 0.
//  ex_hold_i high 3 cycles -> stall_o=00111, flush_o=01000 for 3 cycles, then 0; timeout stays 0.
//  HOLD_MAX=4, ex_hold_i high 10 cycles -> hold_timeout_o=1 from 4th hold cycle, stays 1 until rst.
//  redirect_i and ex_hold_i and load-use same cycle -> redirect actions only; rst during FLUSH -> all outputs 0 next cycle.
//  PERF_EN, NSTAGE=6: 5 stalls+2 redirects -> stall_cnt_o=5, flush_cnt_o=2; flush_o[5] never set.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard/flush controller:
//   controller state encoding, register-index width, flush counter
//   width and the fixed pipeline-register indices that do not move
//   with NSTAGE (pc and if_id).
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FCNT_W     = 3;

    // Register positions that are the same for every pipeline depth
    localparam int STG_PC    = 0;
    localparam int STG_IF_ID = 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
//   Combinational load-use comparator: flags when the instruction in ID
//   reads a register that the load currently in EX will write. x0 never
//   creates a hazard.
// Ports
//   rs1_read / rs1_addr   ID source 1 enable and index
//   rs2_read / rs2_addr   ID source 2 enable and index
//   ex_load / ex_rd_addr  EX instruction is a load, and its destination
//   hazard                load-use hazard present this cycle
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic                  rs1_read,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic                  rs2_read,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  ex_load,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = rs1_read && (rs1_addr == ex_rd_addr);
    assign rs2_match = rs2_read && (rs2_addr == ex_rd_addr);
    assign hazard    = ex_load && (ex_rd_addr != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline hazard/flush controller for an NSTAGE-register in-order core
//   (bit0=pc, 1=if_id, NSTAGE-3=id_ex, NSTAGE-2=ex_mem, ...). Detects
//   load-use hazards, absorbs multi-cycle EX holds and sequences
//   branch-redirect flushes. Priority: redirect > ex_hold > load-use.
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   id_rs1_*/id_rs2_*          ID source-register reads
//   ex_load_i, ex_rd_addr_i    EX load and its destination
//   ex_hold_i                  EX multi-cycle unit busy
//   redirect_i/_addr_i         EX-resolved redirect and target
//   stall_o / flush_o          per-register hold / bubble-insert
//   pc_redirect_o/_addr_o      PC load request and target
//   hold_timeout_o             sticky EX-hold watchdog flag
//   stall_cnt_o, flush_cnt_o   stall-cycle / redirect counters
//                              (only with PIPE_CTRL_PERF_EN defined)
// Configuration macro: PIPE_CTRL_PERF_EN (undefined by default).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE    = 5,
    parameter int XLEN      = 32,
    parameter int FLUSH_CYC = 1,
    parameter int HOLD_MAX  = 64,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_rs1_read_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic                  id_rs2_read_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  ex_load_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_hold_i,
    input  logic                  redirect_i,
    input  logic [XLEN-1:0]       redirect_addr_i,
    output logic [NSTAGE-1:0]     stall_o,
    output logic [NSTAGE-1:0]     flush_o,
    output logic                  pc_redirect_o,
    output logic [XLEN-1:0]       pc_redirect_addr_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
`endif
    output logic                  hold_timeout_o
);

    localparam int EXI    = NSTAGE - 3;
    localparam int HCNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_MAX);
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYC);

    if (NSTAGE < 4 || FLUSH_CYC < 0 || FLUSH_CYC > 7 || HOLD_MAX < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_ctrl: parameter out of range");
    end

    state_e              state_q, state_n;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_n;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_n;
    logic                timeout_q, timeout_n;
    logic                load_use;
    logic                in_flush;

    pipe_ctrl_hazard u_hazard (
        .rs1_read   (id_rs1_read_i),
        .rs1_addr   (id_rs1_addr_i),
        .rs2_read   (id_rs2_read_i),
        .rs2_addr   (id_rs2_addr_i),
        .ex_load    (ex_load_i),
        .ex_rd_addr (ex_rd_addr_i),
        .hazard     (load_use)
    );

    // A flush frozen by an EX hold is still pending while in HOLD, so
    // the remaining if_id flush resumes as soon as the hold drops.
    assign in_flush = (state_q != ST_RUN) && (fcnt_q != '0);

    // State register plus the flush/hold counters and the sticky watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            fcnt_q    <= '0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            fcnt_q    <= fcnt_n;
            hcnt_q    <= hcnt_n;
            timeout_q <= timeout_n;
        end
    end

    // Next state: a redirect restarts the flush sequence, a hold freezes
    // the flush count and accumulates hold cycles, otherwise any pending
    // flush counts down. Any cycle without an active hold clears hcnt.
    always_comb begin
        state_n   = state_q;
        fcnt_n    = fcnt_q;
        hcnt_n    = '0;
        timeout_n = timeout_q;
        if (redirect_i) begin
            fcnt_n  = FCNT_INIT;
            state_n = (FLUSH_CYC > 0) ? ST_FLUSH : ST_RUN;
        end else if (ex_hold_i) begin
            state_n = ST_HOLD;
            hcnt_n  = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HCNT_W'(1);
            if (hcnt_n == HCNT_MAX) begin
                timeout_n = 1'b1;
            end
        end else if (in_flush) begin
            fcnt_n  = fcnt_q - FCNT_W'(1);
            state_n = (fcnt_q == FCNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end else begin
            state_n = ST_RUN;
        end
    end

    // Outputs: decided combinationally from inputs and state, forced to
    // zero while reset is asserted. A load-use from ID is ignored during
    // flush cycles because ID then holds a wrong-path or bubble slot.
    always_comb begin
        stall_o            = '0;
        flush_o            = '0;
        pc_redirect_o      = 1'b0;
        pc_redirect_addr_o = '0;
        if (!rst) begin
            if (redirect_i) begin
                pc_redirect_o      = 1'b1;
                pc_redirect_addr_o = redirect_addr_i;
                for (int k = STG_IF_ID; k <= EXI; k++) begin
                    flush_o[k] = 1'b1;
                end
            end else if (ex_hold_i) begin
                for (int k = STG_PC; k <= EXI; k++) begin
                    stall_o[k] = 1'b1;
                end
                flush_o[EXI+1] = 1'b1;
            end else if (in_flush) begin
                flush_o[STG_IF_ID] = 1'b1;
            end else if (load_use) begin
                for (int k = STG_PC; k < EXI; k++) begin
                    stall_o[k] = 1'b1;
                end
                flush_o[EXI] = 1'b1;
            end
        end
    end

    assign hold_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    // Saturating counters of stalled cycles and of redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if ((|stall_o) && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (pc_redirect_o && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl: a table of single-cycle vectors
//   walked in order (state carries between rows), plus hand-written
//   sequences for reset, reset during flush, the hold watchdog and the
//   counters. A second instance with NSTAGE=6 shares the inputs.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rs1_read, rs2_read, ex_load, ex_hold, redirect;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] redirect_addr;

    logic [4:0]  stall5, flush5;
    logic        redir5, tmo5;
    logic [31:0] addr5;
    logic [5:0]  stall6, flush6;
    logic        redir6, tmo6;
    logic [31:0] addr6;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] scnt5, fcnt5, scnt6, fcnt6;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NSTAGE(5), .XLEN(32), .FLUSH_CYC(1), .HOLD_MAX(4), .CNT_W(16)) u_dut5 (
        .clk(clk), .rst(rst),
        .id_rs1_read_i(rs1_read), .id_rs1_addr_i(rs1_addr),
        .id_rs2_read_i(rs2_read), .id_rs2_addr_i(rs2_addr),
        .ex_load_i(ex_load), .ex_rd_addr_i(rd_addr), .ex_hold_i(ex_hold),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr),
        .stall_o(stall5), .flush_o(flush5),
        .pc_redirect_o(redir5), .pc_redirect_addr_o(addr5),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o(scnt5), .flush_cnt_o(fcnt5),
`endif
        .hold_timeout_o(tmo5)
    );

    pipe_ctrl #(.NSTAGE(6), .XLEN(32), .FLUSH_CYC(1), .HOLD_MAX(4), .CNT_W(16)) u_dut6 (
        .clk(clk), .rst(rst),
        .id_rs1_read_i(rs1_read), .id_rs1_addr_i(rs1_addr),
        .id_rs2_read_i(rs2_read), .id_rs2_addr_i(rs2_addr),
        .ex_load_i(ex_load), .ex_rd_addr_i(rd_addr), .ex_hold_i(ex_hold),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr),
        .stall_o(stall6), .flush_o(flush6),
        .pc_redirect_o(redir6), .pc_redirect_addr_o(addr6),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt_o(scnt6), .flush_cnt_o(fcnt6),
`endif
        .hold_timeout_o(tmo6)
    );

    typedef struct {
        logic        rs1r;
        logic [4:0]  rs1;
        logic        rs2r;
        logic [4:0]  rs2;
        logic        ld;
        logic [4:0]  rd;
        logic        hold;
        logic        redir;
        logic [31:0] addr;
        logic [4:0]  e_stall;
        logic [4:0]  e_flush;
        logic        e_redir;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic rs1r, input logic [4:0] rs1,
                                input logic rs2r, input logic [4:0] rs2,
                                input logic ld, input logic [4:0] rd,
                                input logic hold, input logic redir, input logic [31:0] addr,
                                input logic [4:0] es, input logic [4:0] ef,
                                input logic er, input logic [31:0] ea);
        vec_t v;
        v.rs1r = rs1r; v.rs1 = rs1; v.rs2r = rs2r; v.rs2 = rs2;
        v.ld = ld; v.rd = rd; v.hold = hold; v.redir = redir; v.addr = addr;
        v.e_stall = es; v.e_flush = ef; v.e_redir = er; v.e_addr = ea;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rs1_read = v.rs1r; rs1_addr = v.rs1;
        rs2_read = v.rs2r; rs2_addr = v.rs2;
        ex_load = v.ld; rd_addr = v.rd;
        ex_hold = v.hold; redirect = v.redir; redirect_addr = v.addr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Bits above ex_mem of the six-register instance must never assert
    always @(negedge clk) begin
        checkOutput("n6.bit5", {30'd0, stall6[5], flush6[5]}, 32'd0);
    end

    initial begin
        // rs1r rs1 rs2r rs2 ld rd hold redir addr | stall flush redir addr
        vecs[0]  = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[1]  = mk(1, 5, 0, 0,  1, 5,  0, 0, 0,       5'b00011, 5'b00100, 0, 0);
        vecs[2]  = mk(1, 5, 0, 0,  0, 5,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0,  1, 0,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[4]  = mk(0, 0, 1, 7,  1, 7,  0, 0, 0,       5'b00011, 5'b00100, 0, 0);
        vecs[5]  = mk(0, 7, 1, 3,  1, 7,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[6]  = mk(1, 7, 1, 7,  0, 7,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0,  0, 0,  1, 0, 0,       5'b00111, 5'b01000, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0,  0, 0,  1, 0, 0,       5'b00111, 5'b01000, 0, 0);
        vecs[9]  = mk(1, 9, 0, 0,  1, 9,  1, 0, 0,       5'b00111, 5'b01000, 0, 0);
        vecs[10] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[11] = mk(1, 9, 0, 0,  1, 9,  1, 1, 32'h100, 5'b00000, 5'b00110, 1, 32'h100);
        vecs[12] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00010, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[14] = mk(0, 0, 0, 0,  0, 0,  0, 1, 32'h200, 5'b00000, 5'b00110, 1, 32'h200);
        vecs[15] = mk(0, 0, 0, 0,  0, 0,  1, 0, 0,       5'b00111, 5'b01000, 0, 0);
        vecs[16] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00010, 0, 0);
        vecs[17] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);
        vecs[18] = mk(0, 0, 0, 0,  0, 0,  0, 1, 32'h300, 5'b00000, 5'b00110, 1, 32'h300);
        vecs[19] = mk(0, 0, 0, 0,  0, 0,  0, 1, 32'h400, 5'b00000, 5'b00110, 1, 32'h400);
        vecs[20] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00010, 0, 0);
        vecs[21] = mk(0, 0, 1, 12, 1, 12, 0, 0, 0,       5'b00011, 5'b00100, 0, 0);
        vecs[22] = mk(0, 0, 0, 0,  0, 0,  0, 0, 0,       5'b00000, 5'b00000, 0, 0);

        // Reset with a live load-use on the inputs: everything stays 0
        rst = 1'b1;
        applyStimulus(vecs[1]);
        stepClk();
        #2;
        checkOutput("rst.stall", {27'd0, stall5}, 32'd0);
        checkOutput("rst.flush", {27'd0, flush5}, 32'd0);
        checkOutput("rst.redir", {31'd0, redir5}, 32'd0);
        checkOutput("rst.timeout", {31'd0, tmo5}, 32'd0);
        stepClk();
        rst = 1'b0;
        applyStimulus(vecs[0]);
        stepClk();

        // Table walk: one vector per cycle, outputs checked mid-cycle
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d.stall", i), {27'd0, stall5}, {27'd0, vecs[i].e_stall});
            checkOutput($sformatf("vec%0d.flush", i), {27'd0, flush5}, {27'd0, vecs[i].e_flush});
            checkOutput($sformatf("vec%0d.redir", i), {31'd0, redir5}, {31'd0, vecs[i].e_redir});
            checkOutput($sformatf("vec%0d.addr", i), addr5, vecs[i].e_addr);
            checkOutput($sformatf("vec%0d.addr6", i), addr6, vecs[i].e_addr);
            checkOutput($sformatf("vec%0d.redir6", i), {31'd0, redir6}, {31'd0, vecs[i].e_redir});
            checkOutput($sformatf("vec%0d.timeout", i), {30'd0, tmo6, tmo5}, 32'd0);
            stepClk();
        end

        // Reset during FLUSH: no residual if_id flush afterwards
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0, 0));
        stepClk();
        applyStimulus(vecs[0]);
        rst = 1'b1;
        #2;
        checkOutput("rstflush.during", {22'd0, flush6, flush5}, 32'd0);
        stepClk();
        rst = 1'b0;
        #2;
        checkOutput("rstflush.after", {22'd0, flush6, flush5}, 32'd0);
        checkOutput("rstflush.redir", {31'd0, redir5}, 32'd0);
        stepClk();

        // Watchdog: ten hold cycles with HOLD_MAX=4; flag appears once
        // the fourth hold cycle has completed and stays until reset
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            #2;
            checkOutput($sformatf("hold%0d.stall", k), {27'd0, stall5}, 32'h07);
            checkOutput($sformatf("hold%0d.flush", k), {27'd0, flush5}, 32'h08);
            stepClk();
            checkOutput($sformatf("hold%0d.timeout", k), {30'd0, tmo6, tmo5},
                        (k >= 4) ? 32'd3 : 32'd0);
        end
        applyStimulus(vecs[0]);
        #2;
        checkOutput("holddrop.stall", {27'd0, stall5}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            stepClk();
            checkOutput($sformatf("sticky%0d.timeout", k), {31'd0, tmo5}, 32'd1);
        end
        rst = 1'b1;
        stepClk();
        checkOutput("tmorst.timeout", {30'd0, tmo6, tmo5}, 32'd0);
        rst = 1'b0;
        stepClk();

        // Five load-use stalls then two redirects, from a fresh reset
        applyStimulus(vecs[1]);
        for (int k = 0; k < 5; k++) begin
            #2;
            checkOutput($sformatf("lu6_%0d.stall", k), {26'd0, stall6}, 32'h07);
            checkOutput($sformatf("lu6_%0d.flush", k), {26'd0, flush6}, 32'h08);
            stepClk();
        end
        applyStimulus(vecs[0]);
        stepClk();
        applyStimulus(vecs[14]);
        #2;
        checkOutput("redir6.flush", {26'd0, flush6}, 32'h0E);
        stepClk();
        applyStimulus(vecs[0]);
        stepClk();
        applyStimulus(vecs[18]);
        stepClk();
        applyStimulus(vecs[0]);
        stepClk();
        stepClk();
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf5.stall_cnt", {16'd0, scnt5}, 32'd5);
        checkOutput("perf5.flush_cnt", {16'd0, fcnt5}, 32'd2);
        checkOutput("perf6.stall_cnt", {16'd0, scnt6}, 32'd5);
        checkOutput("perf6.flush_cnt", {16'd0, fcnt6}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
